// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte stream to 32-bit program memory words, holds core in reset until a checksummed image lands
module program_loader #(
    parameter int          PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    input  logic        load_req_i,
    output logic        pm_we_o,
    output logic [31:0] pm_addr_o,
    output logic [31:0] pm_data_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [7:0]  r_csum;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word;
    logic [15:0] r_words;
    logic        r_pm_we;
    logic [31:0] r_pm_addr;
    logic [31:0] r_pm_data;

    logic        w_accept;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic [31:0] w_word_offset;
    logic        w_last_word;

    assign rx_ready_o    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                           (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept      = rx_valid_i && rx_ready_o;
    assign w_len         = {rx_data_i, r_len_lo};
    // Three earlier bytes sit little-endian in r_word; the arriving byte is the top one.
    assign w_word        = {rx_data_i, r_word};
    assign w_word_offset = {14'd0, r_words, 2'b00};
    assign w_last_word   = (r_words + 16'd1) == r_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_LEN0;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_csum     <= 8'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_words    <= 16'd0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= BASE_ADDRESS;
            r_pm_data  <= 32'd0;
        end else begin
            r_pm_we <= 1'b0;
            case (r_state)
                S_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= rx_data_i;
                        r_state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len      <= w_len;
                        r_csum     <= 8'd0;
                        r_byte_idx <= 2'd0;
                        r_words    <= 16'd0;
                        if (w_len > 16'(PROGRAM_MEMORY_DEPTH))
                            r_state <= S_ERR;
                        else if (w_len == 16'd0)
                            r_state <= S_CSUM;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ rx_data_i;
                        r_word     <= {rx_data_i, r_word[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_pm_we   <= 1'b1;
                            r_pm_data <= w_word;
                            r_pm_addr <= BASE_ADDRESS + w_word_offset;
                            r_words   <= r_words + 16'd1;
                            if (w_last_word)
                                r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept)
                        r_state <= (rx_data_i == r_csum) ? S_RUN : S_ERR;
                end
                S_RUN: begin
                    if (load_req_i)
                        r_state <= S_LEN0;
                end
                S_ERR: begin
                    if (load_req_i)
                        r_state <= S_LEN0;
                end
                default: r_state <= S_LEN0;
            endcase
        end
    end

    assign pm_we_o        = r_pm_we;
    assign pm_addr_o      = r_pm_addr;
    assign pm_data_o      = r_pm_data;
    assign words_loaded_o = r_words;
    assign core_reset_o   = (r_state != S_RUN);
    assign busy_o         = rx_ready_o;
    assign error_o        = (r_state == S_ERR);

endmodule
